// File: rtl/alu_result_serializer.sv
// ---------------------------------------------------------------------------
// alu_result_serializer
//
// Takes 16-bit ALU results (for example the shift unit's shift_out/shift_flag
// pair) and sends them toward the byte-wide UART TX FIFO.
//   - A result is captured on the rising edge of res_valid.
//   - It is sent as two bytes, low byte first.
//   - Each byte waits while fifo_full is high.
//   - A result that cannot be accepted is dropped and sets a sticky overrun
//     flag.
//
// Optional feature (compile-time macro ALU_SER_PENDING_EN):
//   A one-entry pending buffer holds one extra result that arrives while a
//   transfer is in progress. Without the macro there is no pending storage,
//   and any capture outside IDLE or a high-byte write edge is dropped.
//
// Parameters:
//   RES_WIDTH  - ALU result width; must equal 2 * BYTE_WIDTH.
//   BYTE_WIDTH - FIFO/UART data width.
//
// Ports:
//   clk        - clock.
//   rst        - asynchronous, active-low reset.
//   res_in     - ALU result; sampled only when a result is captured.
//   res_valid  - ALU result flag (level); its rising edge captures res_in.
//   fifo_full  - TX FIFO full; no byte is written while it is high.
//   ovr_clr    - clears overrun. A drop in the same cycle takes priority.
//   byte_out   - byte presented to the FIFO; 0 when idle.
//   byte_valid - FIFO write strobe; one write per clock edge while high.
//   busy       - a result is held, either being sent or pending.
//   overrun    - sticky; at least one result was dropped.
// ---------------------------------------------------------------------------
module alu_result_serializer #(
  parameter int RES_WIDTH  = 16,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RES_WIDTH-1:0]  res_in,
  input  logic                  res_valid,
  input  logic                  fifo_full,
  input  logic                  ovr_clr,
  output logic [BYTE_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t               state;
  logic [RES_WIDTH-1:0] wrk;
  logic [RES_WIDTH-1:0] pend;
  logic                 pend_v;
  logic                 res_valid_d;

  logic cap;      // rising edge of res_valid
  logic hi_done;  // high byte is written at this edge
  logic drop;     // the captured result has no place to go

  // res_valid_d resets to 0. A level held high across reset release
  // therefore produces exactly one capture.
  assign cap     = res_valid & ~res_valid_d;
  assign hi_done = (state == SEND_HI) & byte_valid;
  assign busy    = (state != IDLE) | pend_v;

  // The strobe is combinational, so a write sees the current fifo_full.
  // The FIFO must raise full in the cycle after the write that fills it.
  assign byte_valid = (state != IDLE) & ~fifo_full;

  // NOTE: every output of an always_comb is given a default first. Without
  // it, a path that skips the assignment infers a latch.
  always_comb begin
    byte_out = '0;
    case (state)
      SEND_LO: byte_out = wrk[BYTE_WIDTH-1:0];
      SEND_HI: byte_out = wrk[RES_WIDTH-1:BYTE_WIDTH];
      default: byte_out = '0;
    endcase
  end

`ifdef ALU_SER_PENDING_EN
  // A capture outside IDLE that is not taken at a high-byte write edge goes
  // to the pending entry if it is free. Otherwise the capture is lost.
  assign drop = cap & (state != IDLE) & ~hi_done & pend_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (hi_done && pend_v) begin
      // The pending result moves to wrk (see the FSM). A capture at the
      // same edge refills the pending entry, so nothing is dropped.
      if (cap) begin
        pend <= res_in;
      end else begin
        pend_v <= 1'b0;
      end
    end else if (cap && (state != IDLE) && !hi_done && !pend_v) begin
      pend   <= res_in;
      pend_v <= 1'b1;
    end
  end
`else
  assign pend   = '0;
  assign pend_v = 1'b0;
  assign drop   = cap & (state != IDLE) & ~hi_done;
`endif

  // Single FSM register block. The working register wrk is reset as well,
  // so byte_out is fully defined from reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wrk         <= '0;
      res_valid_d <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments. All blocks
      // then read the values from before the edge, which avoids ordering
      // races between blocks.
      res_valid_d <= res_valid;
      case (state)
        IDLE: begin
          if (cap) begin
            wrk   <= res_in;
            state <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (byte_valid) begin
            state <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (byte_valid) begin
            // Priority at the write edge: pending entry, then a fresh
            // capture, then IDLE. Either load gives back-to-back results
            // with no idle cycle.
            if (pend_v) begin
              wrk   <= pend;
              state <= SEND_LO;
            end else if (cap) begin
              wrk   <= res_in;
              state <= SEND_LO;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A drop in the same cycle wins over a clear request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_alu_result_serializer
//
// Directed testbench for alu_result_serializer.
//   - Stimulus changes at the falling clock edge.
//   - Outputs are checked 1 time unit later, as the packed tuple
//     {byte_valid, byte_out, busy, overrun}.
//   - A monitor logs every byte that will be written at the next rising
//     edge, so the exact number and order of FIFO writes can be checked.
//   - Building with ALU_SER_PENDING_EN selects the pending-buffer scenario;
//     otherwise the drop scenario runs.
// ---------------------------------------------------------------------------
module tb_alu_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] res_in;
  logic        res_valid;
  logic        fifo_full;
  logic        ovr_clr;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rv;
    logic        ff;
    logic        clr;
    logic [15:0] din;
  } stim_t;

  typedef struct packed {
    logic       bv;
    logic [7:0] bo;
    logic       busy;
    logic       ovr;
  } obs_t;

  obs_t       obs;
  logic [7:0] wr_q[$];

  alu_result_serializer #(.RES_WIDTH(16), .BYTE_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .res_in     (res_in),
    .res_valid  (res_valid),
    .fifo_full  (fifo_full),
    .ovr_clr    (ovr_clr),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  assign obs = {byte_valid, byte_out, busy, overrun};

  // Inputs are stable from negedge+1 until the next posedge. A strobe seen
  // here is therefore a write at the coming rising edge.
  always @(negedge clk) begin
    #2;
    if (rst && byte_valid) wr_q.push_back(byte_out);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic drive(input stim_t s);
    res_valid = s.rv;
    fifo_full = s.ff;
    ovr_clr   = s.clr;
    res_in    = s.din;
  endtask

  // Packs the logged writes as {count, last four bytes, oldest first}.
  function automatic logic [39:0] writes_packed();
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < wr_q.size(); i++) b = {b[23:0], wr_q[i]};
    return {8'(wr_q.size()), b};
  endfunction

  task automatic test_reset();
    drive('0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== obs_t'('0)) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, obs_t'('0));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs, obs_t'('0));
    end
  endtask

  task automatic test_basic();
    stim_t st[4];
    obs_t  ex[4];
    for (int i = 0; i < 4; i++) begin
      st[i] = '0;
      ex[i] = '0;
    end
    st[0] = '{1'b1, 1'b0, 1'b0, 16'hA55A};
    ex[1] = '{1'b1, 8'h5A, 1'b1, 1'b0};
    ex[2] = '{1'b1, 8'hA5, 1'b1, 1'b0};
    wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(st[i]);
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL basic cyc%0d: got %h want %h", i, obs, ex[i]);
      end
    end
    checks++;
    if (writes_packed() !== {8'd2, 32'h00005AA5}) begin
      errors++;
      $display("FAIL basic_writes: got %h want %h", writes_packed(), {8'd2, 32'h00005AA5});
    end
  endtask

  task automatic test_level_hold();
    stim_t st[11];
    obs_t  ex[11];
    for (int i = 0; i < 11; i++) begin
      st[i] = '{(i < 10), 1'b0, 1'b0, 16'h1234};
      ex[i] = '0;
    end
    ex[1] = '{1'b1, 8'h34, 1'b1, 1'b0};
    ex[2] = '{1'b1, 8'h12, 1'b1, 1'b0};
    wr_q.delete();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(st[i]);
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL level_hold cyc%0d: got %h want %h", i, obs, ex[i]);
      end
    end
    checks++;
    if (writes_packed() !== {8'd2, 32'h00003412}) begin
      errors++;
      $display("FAIL level_hold_writes: got %h want %h", writes_packed(), {8'd2, 32'h00003412});
    end
  endtask

  task automatic test_stall();
    stim_t st[9];
    obs_t  ex[9];
    for (int i = 0; i < 9; i++) begin
      st[i] = '{1'b0, (i >= 2 && i <= 6), 1'b0, 16'h0000};
      ex[i] = '0;
    end
    st[0] = '{1'b1, 1'b0, 1'b0, 16'hBEEF};
    ex[1] = '{1'b1, 8'hEF, 1'b1, 1'b0};
    for (int i = 2; i <= 6; i++) ex[i] = '{1'b0, 8'hBE, 1'b1, 1'b0};
    ex[7] = '{1'b1, 8'hBE, 1'b1, 1'b0};
    wr_q.delete();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(st[i]);
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL stall cyc%0d: got %h want %h", i, obs, ex[i]);
      end
    end
    checks++;
    if (writes_packed() !== {8'd2, 32'h0000EFBE}) begin
      errors++;
      $display("FAIL stall_writes: got %h want %h", writes_packed(), {8'd2, 32'h0000EFBE});
    end
  endtask

`ifdef ALU_SER_PENDING_EN
  // 0102 is being sent; 0304 goes to the pending entry while the low byte
  // is stalled; 0506 arrives while the entry is full and is dropped.
  task automatic test_back_to_back();
    stim_t st[10];
    obs_t  ex[10];
    for (int i = 0; i < 10; i++) begin
      st[i] = '0;
      ex[i] = '0;
    end
    st[0] = '{1'b1, 1'b0, 1'b0, 16'h0102};
    st[1] = '{1'b0, 1'b1, 1'b0, 16'h0000};
    st[2] = '{1'b1, 1'b1, 1'b0, 16'h0304};
    st[3] = '{1'b0, 1'b1, 1'b0, 16'h0000};
    st[4] = '{1'b1, 1'b0, 1'b0, 16'h0506};
    st[8] = '{1'b0, 1'b0, 1'b1, 16'h0000};
    ex[1] = '{1'b0, 8'h02, 1'b1, 1'b0};
    ex[2] = '{1'b0, 8'h02, 1'b1, 1'b0};
    ex[3] = '{1'b0, 8'h02, 1'b1, 1'b0};
    ex[4] = '{1'b1, 8'h02, 1'b1, 1'b0};
    ex[5] = '{1'b1, 8'h01, 1'b1, 1'b1};
    ex[6] = '{1'b1, 8'h04, 1'b1, 1'b1};
    ex[7] = '{1'b1, 8'h03, 1'b1, 1'b1};
    ex[8] = '{1'b0, 8'h00, 1'b0, 1'b1};
    wr_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(st[i]);
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL pending cyc%0d: got %h want %h", i, obs, ex[i]);
      end
    end
    checks++;
    if (writes_packed() !== {8'd4, 32'h02010403}) begin
      errors++;
      $display("FAIL pending_writes: got %h want %h", writes_packed(), {8'd4, 32'h02010403});
    end
  endtask
`else
  // 9999 is captured during a stalled low byte and dropped. The clear
  // request in that same cycle loses to the drop. 3344 arrives exactly at
  // the high-byte write edge and is accepted with no gap.
  task automatic test_back_to_back();
    stim_t st[8];
    obs_t  ex[8];
    for (int i = 0; i < 8; i++) begin
      st[i] = '0;
      ex[i] = '0;
    end
    st[0] = '{1'b1, 1'b0, 1'b0, 16'h1122};
    st[1] = '{1'b0, 1'b1, 1'b0, 16'h0000};
    st[2] = '{1'b1, 1'b1, 1'b1, 16'h9999};
    st[3] = '{1'b0, 1'b0, 1'b1, 16'h0000};
    st[4] = '{1'b1, 1'b0, 1'b0, 16'h3344};
    ex[1] = '{1'b0, 8'h22, 1'b1, 1'b0};
    ex[2] = '{1'b0, 8'h22, 1'b1, 1'b0};
    ex[3] = '{1'b1, 8'h22, 1'b1, 1'b1};
    ex[4] = '{1'b1, 8'h11, 1'b1, 1'b0};
    ex[5] = '{1'b1, 8'h44, 1'b1, 1'b0};
    ex[6] = '{1'b1, 8'h33, 1'b1, 1'b0};
    wr_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(st[i]);
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL drop cyc%0d: got %h want %h", i, obs, ex[i]);
      end
    end
    checks++;
    if (writes_packed() !== {8'd4, 32'h22114433}) begin
      errors++;
      $display("FAIL drop_writes: got %h want %h", writes_packed(), {8'd4, 32'h22114433});
    end
  endtask
`endif

  task automatic test_reset_mid();
    obs_t ex[8];
    for (int i = 0; i < 8; i++) ex[i] = '0;
    ex[1] = '{1'b1, 8'hFE, 1'b1, 1'b0};
    wr_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive('{(i == 0), 1'b0, 1'b0, 16'hCAFE});
      rst = (i != 2);
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs, ex[i]);
      end
    end
    checks++;
    if (writes_packed() !== {8'd1, 32'h000000FE}) begin
      errors++;
      $display("FAIL reset_mid_writes: got %h want %h", writes_packed(), {8'd1, 32'h000000FE});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_hold();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Drains 16-bit ALU results, such as the shift unit's `shift_out`/`shift_flag` pair, toward the byte-wide UART TX path. A result is captured on the rising edge of its valid flag, split into two bytes, and pushed low byte first into the TX FIFO under `fifo_full` backpressure. An optional one-entry pending buffer absorbs a second result that arrives while a transfer is in progress. A sticky overrun flag reports any result that is dropped.

## Interface
- `RES_WIDTH`, 16, ALU result width; must equal 2 × `BYTE_WIDTH`.
- `BYTE_WIDTH`, 8, FIFO/UART data width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `res_in` in `RES_WIDTH`: ALU result data; sampled only on a capture.
- `res_valid` in 1: ALU result flag; level signal, held high while the ALU function is enabled.
- `fifo_full` in 1: TX FIFO full; a byte is not written while it is high.
- `ovr_clr` in 1: clears `overrun`.
- `byte_out` out `BYTE_WIDTH`: byte to the FIFO.
- `byte_valid` out 1: FIFO write strobe; a write occurs at every clock edge where it is high.
- `busy` out 1: high whenever a result is held (working or pending).
- `overrun` out 1: sticky; a result was dropped.

## Operation
- Edge detect: `cap = res_valid & ~res_valid_d`. `res_valid_d` is a register that resets to 0. A level held high across reset release therefore captures once.
- FSM states: IDLE, SEND_LO, SEND_HI. The working register `wrk` holds the full result.
- IDLE: on `cap`, load `wrk <= res_in` and go to SEND_LO.
- SEND_LO:
  - `byte_out = wrk[7:0]`.
  - `byte_valid = ~fifo_full`.
  - Advance to SEND_HI at an edge where `byte_valid` is high; otherwise hold.
- SEND_HI:
  - `byte_out = wrk[15:8]`.
  - `byte_valid = ~fifo_full`.
  - At the write edge, select the next state by priority:
    1. If the pending entry is valid: `wrk <= pending`, go to SEND_LO.
    2. Else if `cap`: `wrk <= res_in`, go to SEND_LO.
    3. Else go to IDLE.
- `byte_valid` is combinational from state and `fifo_full`. `byte_out` is driven from `wrk` and is 0 in IDLE.
- `busy = (state != IDLE) | pend_v`.
- `cap` while not in IDLE and not consumed at a SEND_HI write edge follows the Configuration rules.
- `overrun`:
  - Set on a drop.
  - Cleared by `ovr_clr` when no drop occurs in the same cycle. A set in the same cycle as `ovr_clr` wins.
- Reset mid-transfer: the FSM, `wrk`, pending entry and `res_valid_d` are cleared, and any partially sent result is abandoned. No byte_valid is asserted during reset.

## Timing
- Reset values:
  - `byte_out` = 0.
  - `byte_valid` = 0.
  - `busy` = 0.
  - `overrun` = 0.
  - Internal: state IDLE, `wrk` = 0, pending entry = 0 / invalid, `res_valid_d` = 0.
- Latency: `cap` is sampled at edge E, giving SEND_LO in cycle E+1. With `fifo_full` low throughout:
  - Low byte written at edge E+1.
  - High byte written at edge E+2.
  - `busy` falls after E+2 if nothing is pending.
- Throughput: 2 cycles per result. There are no idle cycles between back-to-back results.
- `fifo_full` stalls in place with no limit. `byte_out` is held stable while stalled.
- The FIFO's full flag must reflect a write by the next cycle, so no byte is written into a full FIFO.

## Configuration
- `ALU_SER_PENDING_EN` defined:
  - One-entry pending register `pend`/`pend_v`.
  - `cap` while not IDLE with `pend_v = 0`: `pend <= res_in`, `pend_v <= 1`.
  - `cap` with `pend_v = 1`: the new result is dropped and `overrun` is set.
  - At a SEND_HI write edge with both `pend_v = 1` and `cap`: pending moves to `wrk` and the new result moves into `pend`. No overrun.
- `ALU_SER_PENDING_EN` undefined:
  - No pending storage; `pend_v` is constant 0.
  - Any `cap` not accepted in IDLE or at a SEND_HI write edge is dropped and sets `overrun`.

## Test plan
- Reset release, `res_valid` rises with `res_in = 16'hA55A`, `fifo_full = 0` → `byte_valid` high 2 consecutive cycles, bytes `8'h5A` then `8'hA5`, then `busy = 0`.
- `res_valid` held high for 10 cycles with `res_in = 16'h1234` → exactly 2 writes (`8'h34`, `8'h12`), no repeat.
- `fifo_full` high for 5 cycles during SEND_HI of `16'hBEEF` → `byte_out = 8'hBE` held stable, `byte_valid = 0` for 5 cycles, then one write.
- With `ALU_SER_PENDING_EN`: captures `16'h0102`, `16'h0304` (during the first transfer), `16'h0506` (while the pending entry is full) → bytes `02 01 04 03` back-to-back, `overrun = 1`; then `ovr_clr` → `overrun = 0`.
- Without `ALU_SER_PENDING_EN`: second capture during SEND_LO → dropped, `overrun = 1`. A capture coinciding with the high-byte write edge → accepted, 4 bytes total, no overrun.
- `rst` asserted in SEND_HI of `16'hCAFE` → outputs return to reset values immediately. The high byte is never sent, and no write occurs after reset release until a new `res_valid` edge.
